// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO stream reader family.
//   DATA_W_DEFAULT : default data word width
//   DEPTH_MIN/MAX  : legal range for the skid/output buffer depth
//   level_width()  : bits needed to hold a count of 0..depth
package fifo_pkg;

    localparam int DATA_W_DEFAULT = 9;
    localparam int DEPTH_MIN      = 2;
    localparam int DEPTH_MAX      = 8;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_skid_buf.sv
// Depth-entry circular buffer with registered pointers and occupancy.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write a word at the write pointer
//   pop             : retire the head word
//   head_data       : word at the read pointer (registered storage)
//   level           : number of words held
//   overflow        : push refused because the buffer is full with no pop
module fifo_stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int Width      = DATA_W_DEFAULT,
    parameter int Depth      = 3,
    parameter int LevelWidth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [Width-1:0]      push_data,
    input  logic                  pop,
    output logic [Width-1:0]      head_data,
    output logic [LevelWidth-1:0] level,
    output logic                  overflow
);

    localparam int                    PtrW    = $clog2(Depth);
    localparam logic [PtrW-1:0]       LastPtr = PtrW'(Depth - 1);
    localparam logic [LevelWidth-1:0] Full    = LevelWidth'(Depth);

    logic [Width-1:0]      mem_q [Depth];
    logic [Width-1:0]      mem_d [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  pop_ok, push_ok;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        pop_ok   = pop && (level_q != '0);
        // A pop in the same cycle frees the slot the push lands in.
        push_ok  = push && ((level_q != Full) || pop_ok);
        overflow = push && !push_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LevelWidth'(1);
            2'b01:   level_d = level_q - LevelWidth'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a standard-mode (1-cycle read latency) block RAM FIFO and presents
// the words as a valid/ready stream from a small registered buffer.
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   FifoEmpty, FifoRead : FIFO empty flag in, read strobe out
//   FifoDout, FifoValid : FIFO read data, valid one cycle after FifoRead
//   OutValid, OutReady, OutData : downstream stream
//   Level               : words currently buffered
//   ProtoErr            : sticky protocol error
// Build option: define FIFO_STREAM_READER_CHECK_EN to enable the protocol
// checker behind ProtoErr; otherwise ProtoErr is tied low.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int Width      = DATA_W_DEFAULT,
    parameter int Depth      = 3,
    parameter int LevelWidth = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FifoEmpty,
    output logic                  FifoRead,
    input  logic [Width-1:0]      FifoDout,
    input  logic                  FifoValid,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [Width-1:0]      OutData,
    output logic [LevelWidth-1:0] Level,
    output logic                  ProtoErr
);

    if (Depth < DEPTH_MIN || Depth > DEPTH_MAX) begin : g_bad_depth
        $error("fifo_stream_reader: Depth out of range");
    end
    if (LevelWidth < level_width(Depth)) begin : g_bad_level_w
        $error("fifo_stream_reader: LevelWidth too narrow for Depth");
    end

    logic                  in_flight_q, in_flight_d;
    logic                  fifo_read;
    logic                  buf_pop;
    logic                  buf_overflow;
    logic [LevelWidth-1:0] level;
    logic [Width-1:0]      head_data;

    // Read issue depends only on FifoEmpty and registered state; counting the
    // in-flight word reserves its slot so the buffer can never be overrun.
    always_comb begin
        fifo_read = 1'b0;
        if (!Reset && !FifoEmpty && ((int'(level) + int'(in_flight_q)) < Depth)) begin
            fifo_read = 1'b1;
        end
        in_flight_d = fifo_read;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign OutValid = (level != '0);
    assign buf_pop  = OutValid && OutReady;

    fifo_stream_skid_buf #(
        .Width      (Width),
        .Depth      (Depth),
        .LevelWidth (LevelWidth)
    ) u_skid (
        .clk       (Clk),
        .rst       (Reset),
        .push      (FifoValid),
        .push_data (FifoDout),
        .pop       (buf_pop),
        .head_data (head_data),
        .level     (level),
        .overflow  (buf_overflow)
    );

    assign FifoRead = fifo_read;
    assign OutData  = head_data;
    assign Level    = level;

`ifdef FIFO_STREAM_READER_CHECK_EN
    logic proto_err_q, proto_err_d;

    // FifoValid must mirror last cycle's read exactly; any disagreement
    // (unsolicited or missing data) or a dropped word latches the flag.
    always_comb begin
        proto_err_d = proto_err_q | (FifoValid != in_flight_q) | buf_overflow;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign ProtoErr = proto_err_q;
`else
    logic unused_overflow;
    assign unused_overflow = buf_overflow;
    assign ProtoErr        = 1'b0;
`endif

endmodule
